svc_rv_dmem_model: RTL and testbench
====================================

// Module: svc_rv_dmem_model
//
// PURPOSE
// Behavioural data memory sitting directly downstream of the svc_rv dmem port.
// Byte-strobed word array with SRAM (0-cycle) or BRAM (1-cycle) read timing.
// Generates a bounded, cache-like dmem_stall only while a read is pending, and
// holds dmem_rdata stable throughout the stall. Used in sim benches and SoC tops.
//
// PARAMETERS
// AW         10   word-address bits; depth = 2**AW words
// MEM_TYPE   0    0 = SRAM (combinational read), 1 = BRAM (registered read)
// STALL_MAX  2    max consecutive stall cycles per read; 0 disables stalling
// INIT_WORD  0    initial value of every word (sim init only, not reset)
//
// PORTS
// clock       in   1   sole clock, rising edge
// reset       in   1   synchronous, active-high
// stall_req   in   1   stall request (bench random/pattern); ignored if no read pending
// dmem_ren    in   1   read request
// dmem_raddr  in   32  byte address; word index = raddr[AW+1:2]
// dmem_rdata  out  32  read data
// dmem_we     in   1   write request
// dmem_waddr  in   32  byte address; word index = waddr[AW+1:2]
// dmem_wdata  in   32  write data
// dmem_wstrb  in   4   byte enables, bit i -> wdata[8i+7:8i]
// dmem_stall  out  1   core must hold its MEM stage while high
// stall_cnt   out  32  total stall cycles since reset (saturating)
//
// BEHAVIOUR
// - Reset: dmem_stall=0, stall_cnt=0, dmem_rdata=0, pending=0, run=0. Memory is not reset.
// - Accept: read accepted on cycle where dmem_ren && !dmem_stall; write likewise.
// - FSM {IDLE, PEND}: IDLE->PEND on accepted read; PEND->PEND on accepted read;
//   PEND->IDLE when !dmem_stall and !dmem_ren.
// - dmem_stall = !reset && PEND && stall_req && (run < STALL_MAX). Mealy on stall_req.
// - run: 2-bit consecutive-stall counter.
//   Increments on every stall cycle, clears on any non-stall cycle.
//   Forces stall low once run==STALL_MAX.
// - BRAM read: rdata register loads mem[raddr idx] on accepted read.
//   Holds otherwise, including all stall cycles. Data is visible the cycle after acceptance.
// - SRAM read: latch idx on accepted read.
//   dmem_rdata = dmem_ren && !dmem_stall ? mem[raddr idx] : mem[latched idx].
// - Write: on accepted write, apply wstrb bytewise at the clock edge. Writes during a stall are dropped.
// - Same-cycle read+write to same word: read-first. Old data is returned; the new data is visible to the next read.
// - Address wrap: bits above AW+1 and bits [1:0] are ignored; idx 2**AW-1 + 1 wraps to 0.
// - wstrb==0 with we: accepted, no change.
// - stall_cnt increments on every cycle dmem_stall=1 and saturates at 32'hFFFF_FFFF.
// - Reset mid-stall: dmem_stall drops in the same cycle reset is high.
//   Pending is cleared and the rdata register becomes 0 at the edge.
//
// STRUCTURE
// - svc_rv_mem_pkg: MEM_TYPE_SRAM/MEM_TYPE_BRAM localparams, dmem_state_t {IDLE, PEND}.
// - Sub-module svc_rv_dmem_stall_ctl: FSM, run counter, dmem_stall, stall_cnt.
// - Top level: array, strobed write, SRAM/BRAM read generate branches.
//
// TESTING
// 1. Reset, BRAM, stall_req=0. Write 0xDEADBEEF wstrb=F @0x40, then read @0x40.
//    Expect rdata=0xDEADBEEF the next cycle, stall never high.
// 2. Byte strobes: word 0x11223344 @0x8, then write 0xAABBCCDD wstrb=4'b0101.
//    Read @0x8 gives 0x11BB33DD.
// 3. Bounded stall, BRAM, STALL_MAX=2. Read @0x40 with stall_req held high.
//    dmem_stall is high exactly 2 cycles, rdata holds 0xDEADBEEF throughout, stall_cnt=2.
// 4. stall_req=1 with no read pending: dmem_stall stays 0. Then a write during a stall:
//    that word is unchanged afterwards.
// 5. Wrap and read-first, AW=10. Write 0x5 @0x1000 and read @0x0 in the same cycle.
//    The read returns the old value; the next read @0x0 returns 0x5.
// 6. Assert reset during the second stall cycle: dmem_stall=0 in that cycle.
//    Next cycle stall_cnt=0, rdata=0, a fresh read is accepted immediately.

Source files
------------

// File: rtl/svc_rv_mem_pkg.sv
// Shared constants and state encoding for the svc_rv behavioural memory models.
package svc_rv_mem_pkg;

   localparam int MEM_TYPE_SRAM = 0;
   localparam int MEM_TYPE_BRAM = 1;

   typedef enum logic {
      IDLE,
      PEND
   } dmem_state_t;

endpackage

// File: rtl/svc_rv_dmem_stall_ctl.sv
// Read-pending tracker for the dmem model: produces a bounded, Mealy stall
// and a saturating count of stall cycles.
module svc_rv_dmem_stall_ctl #(
   parameter int STALL_MAX = 2
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall_req,
   input  logic        dmem_ren,
   output logic        dmem_stall,
   output logic [31:0] stall_cnt
);
   import svc_rv_mem_pkg::*;

   localparam logic [2:0] STALL_LIM = 3'(STALL_MAX);

   dmem_state_t state_q, state_d;
   logic [1:0]  run_q, run_d;
   logic        rd_acc;

   always_comb begin
      dmem_stall = !reset && (state_q == PEND) && stall_req && ({1'b0, run_q} < STALL_LIM);
      rd_acc     = dmem_ren && !dmem_stall;
      run_d      = dmem_stall ? run_q + 2'd1 : '0;
      state_d    = state_q;
      case (state_q)
         IDLE:    if (rd_acc) state_d = PEND;
         PEND:    if (!rd_acc && !dmem_stall && !dmem_ren) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q   <= IDLE;
         run_q     <= '0;
         stall_cnt <= '0;
      end else begin
         state_q <= state_d;
         run_q   <= run_d;
         if (dmem_stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 32'd1;
      end
   end

endmodule

// File: rtl/svc_rv_dmem_model.sv
// Behavioural byte-strobed data memory for the svc_rv dmem port, with
// selectable SRAM/BRAM read timing and a bounded stall generator.
module svc_rv_dmem_model #(
   parameter int          AW        = 10,
   parameter int          MEM_TYPE  = 0,
   parameter int          STALL_MAX = 2,
   parameter logic [31:0] INIT_WORD = 32'h0
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        stall_req,
   input  logic        dmem_ren,
   input  logic [31:0] dmem_raddr,
   output logic [31:0] dmem_rdata,
   input  logic        dmem_we,
   input  logic [31:0] dmem_waddr,
   input  logic [31:0] dmem_wdata,
   input  logic [3:0]  dmem_wstrb,
   output logic        dmem_stall,
   output logic [31:0] stall_cnt
);
   import svc_rv_mem_pkg::*;

   localparam int DEPTH = 2 ** AW;

   logic [31:0]   mem [DEPTH] = '{default: INIT_WORD};
   logic [AW-1:0] ridx, widx;
   logic          rd_acc, wr_acc;
   logic          unused_addr_bits;

   assign ridx   = dmem_raddr[AW+1:2];
   assign widx   = dmem_waddr[AW+1:2];
   assign rd_acc = dmem_ren && !dmem_stall;
   assign wr_acc = dmem_we && !dmem_stall;

   // Upper and byte-offset address bits are deliberately ignored (wrap).
   assign unused_addr_bits = ^{dmem_raddr[31:AW+2], dmem_raddr[1:0],
                               dmem_waddr[31:AW+2], dmem_waddr[1:0]};

   svc_rv_dmem_stall_ctl #(
      .STALL_MAX(STALL_MAX)
   ) u_stall_ctl (
      .clock     (clock),
      .reset     (reset),
      .stall_req (stall_req),
      .dmem_ren  (dmem_ren),
      .dmem_stall(dmem_stall),
      .stall_cnt (stall_cnt)
   );

   always_ff @(posedge clock) begin
      if (wr_acc) begin
         for (int unsigned i = 0; i < 4; i++) begin
            if (dmem_wstrb[i]) mem[widx][8*i +: 8] <= dmem_wdata[8*i +: 8];
         end
      end
   end

   // Reads sample the array before this edge's write lands, giving read-first.
   if (MEM_TYPE == MEM_TYPE_BRAM) begin : g_bram
      logic [31:0] rdata_q;
      always_ff @(posedge clock) begin
         if (reset)       rdata_q <= '0;
         else if (rd_acc) rdata_q <= mem[ridx];
      end
      assign dmem_rdata = rdata_q;
   end else begin : g_sram
      logic [AW-1:0] idx_q;
      always_ff @(posedge clock) begin
         if (reset)       idx_q <= '0;
         else if (rd_acc) idx_q <= ridx;
      end
      assign dmem_rdata = rd_acc ? mem[ridx] : mem[idx_q];
   end

endmodule

// File: tb/tb_svc_rv_dmem_model.sv
// Scoreboard bench for svc_rv_dmem_model in BRAM mode with STALL_MAX=2.
module tb_svc_rv_dmem_model;

   localparam int K_RDATA = 0;
   localparam int K_STALL = 1;
   localparam int K_CNT   = 2;

   typedef struct {
      int          cyc;
      int          kind;
      logic [31:0] val;
      string       name;
   } exp_t;

   logic        clock = 1'b0;
   logic        reset;
   logic        stall_req;
   logic        dmem_ren;
   logic [31:0] dmem_raddr;
   logic [31:0] dmem_rdata;
   logic        dmem_we;
   logic [31:0] dmem_waddr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_wstrb;
   logic        dmem_stall;
   logic [31:0] stall_cnt;

   int   cyc = 0;
   int   total = 0;
   int   bad = 0;
   exp_t sb[$];
   logic done = 1'b0;

   svc_rv_dmem_model #(
      .AW       (10),
      .MEM_TYPE (1),
      .STALL_MAX(2),
      .INIT_WORD(32'h0)
   ) dut (
      .clock     (clock),
      .reset     (reset),
      .stall_req (stall_req),
      .dmem_ren  (dmem_ren),
      .dmem_raddr(dmem_raddr),
      .dmem_rdata(dmem_rdata),
      .dmem_we   (dmem_we),
      .dmem_waddr(dmem_waddr),
      .dmem_wdata(dmem_wdata),
      .dmem_wstrb(dmem_wstrb),
      .dmem_stall(dmem_stall),
      .stall_cnt (stall_cnt)
   );

   always #5 clock = ~clock;
   always @(posedge clock) cyc <= cyc + 1;

   task automatic expect_now(input int kind, input logic [31:0] val, input string name);
      exp_t e;
      e.cyc = cyc; e.kind = kind; e.val = val; e.name = name;
      sb.push_back(e);
   endtask

   task automatic expect_next(input int kind, input logic [31:0] val, input string name);
      exp_t e;
      e.cyc = cyc + 1; e.kind = kind; e.val = val; e.name = name;
      sb.push_back(e);
   endtask

   task automatic step();
      @(posedge clock);
      #1;
   endtask

   task automatic idle_inputs();
      dmem_ren = 1'b0; dmem_raddr = '0;
      dmem_we = 1'b0; dmem_waddr = '0; dmem_wdata = '0; dmem_wstrb = '0;
   endtask

   task automatic wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      dmem_we = 1'b1; dmem_waddr = a; dmem_wdata = d; dmem_wstrb = s;
   endtask

   task automatic rd(input logic [31:0] a);
      dmem_ren = 1'b1; dmem_raddr = a;
   endtask

   // Monitor: outputs are sampled mid-cycle and checked against queued entries.
   always @(negedge clock) begin
      logic [31:0] act;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         exp_t e;
         e = sb.pop_front();
         total++;
         case (e.kind)
            K_RDATA: act = dmem_rdata;
            K_STALL: act = {31'b0, dmem_stall};
            default: act = stall_cnt;
         endcase
         if (e.cyc < cyc) begin
            bad++;
            $display("FAIL %s: check for cycle %0d missed (now %0d)", e.name, e.cyc, cyc);
         end else if (act !== e.val) begin
            bad++;
            $display("FAIL %s: cycle %0d got %h expected %h", e.name, cyc, act, e.val);
         end
      end
   end

   initial begin
      reset = 1'b1; stall_req = 1'b0; idle_inputs();
      step(); step();
      expect_now(K_STALL, 32'h0, "reset_stall");
      expect_now(K_CNT,   32'h0, "reset_cnt");
      expect_now(K_RDATA, 32'h0, "reset_rdata");
      step();
      reset = 1'b0;

      // 1: full write then BRAM read
      wr(32'h40, 32'hDEADBEEF, 4'hF);
      step();
      idle_inputs(); rd(32'h40);
      expect_now(K_STALL, 32'h0, "t1_nostall");
      step();
      idle_inputs();
      expect_now(K_RDATA, 32'hDEADBEEF, "t1_rdata");
      step();

      // 2: byte strobes, then wstrb==0 write is a no-op
      wr(32'h8, 32'h11223344, 4'hF);
      step();
      wr(32'h8, 32'hAABBCCDD, 4'b0101);
      step();
      idle_inputs(); rd(32'h8);
      step();
      idle_inputs();
      expect_now(K_RDATA, 32'h11BB33DD, "t2_strobe");
      wr(32'h8, 32'hFFFFFFFF, 4'h0);
      step();
      idle_inputs(); rd(32'h8);
      step();
      idle_inputs();
      expect_now(K_RDATA, 32'h11BB33DD, "t2_wstrb0");
      step();

      // 3: bounded stall with stall_req held
      rd(32'h40); stall_req = 1'b1;
      expect_now(K_STALL, 32'h0, "t3_accept");
      step();
      idle_inputs();
      expect_now(K_STALL, 32'h1, "t3_stall1");
      expect_now(K_RDATA, 32'hDEADBEEF, "t3_hold1");
      step();
      expect_now(K_STALL, 32'h1, "t3_stall2");
      expect_now(K_RDATA, 32'hDEADBEEF, "t3_hold2");
      expect_now(K_CNT,   32'h1, "t3_cnt1");
      step();
      expect_now(K_STALL, 32'h0, "t3_bound");
      expect_now(K_RDATA, 32'hDEADBEEF, "t3_hold3");
      expect_now(K_CNT,   32'h2, "t3_cnt2");
      step();

      // 4: no read pending -> no stall; write during stall is dropped
      expect_now(K_STALL, 32'h0, "t4_no_pend");
      step();
      stall_req = 1'b0; rd(32'h40);
      step();
      idle_inputs(); stall_req = 1'b1;
      wr(32'h40, 32'h0, 4'hF);
      expect_now(K_STALL, 32'h1, "t4_stall");
      step();
      idle_inputs(); stall_req = 1'b0;
      expect_now(K_STALL, 32'h0, "t4_release");
      expect_now(K_CNT,   32'h3, "t4_cnt");
      step();
      rd(32'h40);
      expect_next(K_RDATA, 32'hDEADBEEF, "t4_dropped");
      step();
      idle_inputs();
      step();

      // 5: address wrap and read-first on the same word
      wr(32'h1000, 32'h5, 4'hF); rd(32'h0);
      expect_next(K_RDATA, 32'h0, "t5_read_first");
      step();
      idle_inputs(); rd(32'h0);
      expect_next(K_RDATA, 32'h5, "t5_new_data");
      step();
      idle_inputs();
      step();

      // 6: reset during the second stall cycle
      rd(32'h40); stall_req = 1'b1;
      step();
      idle_inputs();
      expect_now(K_STALL, 32'h1, "t6_stall1");
      expect_now(K_CNT,   32'h3, "t6_cnt_pre");
      step();
      reset = 1'b1;
      expect_now(K_STALL, 32'h0, "t6_reset_stall");
      step();
      reset = 1'b0;
      rd(32'h8);
      expect_now(K_CNT,   32'h0, "t6_cnt_clr");
      expect_now(K_RDATA, 32'h0, "t6_rdata_clr");
      expect_now(K_STALL, 32'h0, "t6_fresh_accept");
      expect_next(K_RDATA, 32'h11BB33DD, "t6_fresh_data");
      step();
      idle_inputs(); stall_req = 1'b0;
      step(); step();

      if (sb.size() != 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb.size());
      end
      done = 1'b1;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #100000;
      if (!done) begin
         $display("FAIL watchdog: time limit reached, expected completion");
         $fatal(1, "watchdog");
      end
   end

endmodule
